dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words in the array (power of two, at least 2).
REQ-002 Parameter LATENCY, default 2, number of falling edges from request acceptance to rsp_valid assertion (at least 1).
REQ-003 clock  input  1  sole clock; all state changes on its falling edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  requester presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  requester accepts the response.
REQ-012 rsp_data  output  32  load data, or the stored data for a store.
REQ-013 rsp_err  output  1  error flag (see Configuration).

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-016 A request is accepted on a falling edge with req_valid=1 and req_ready=1; op, address and wdata SHALL be captured at that edge, and later input changes SHALL be ignored.
REQ-017 Word index SHALL be (req_addr>>2) modulo DEPTH; high address bits wrap silently.
REQ-018 On acceptance the FSM SHALL go to RESP if LATENCY=1, otherwise to WAIT with a down-counter loaded with LATENCY-1.
REQ-019 In WAIT the counter SHALL decrement each falling edge; on the edge where it reaches 0 the FSM SHALL enter RESP.
REQ-020 The array access SHALL occur on the edge entering RESP: a store writes the word, a load captures it into rsp_data.
REQ-021 For a store, rsp_data SHALL equal the captured wdata.
REQ-022 rsp_valid, rsp_data and rsp_err SHALL hold stable in RESP until a falling edge with rsp_ready=1, which SHALL return the FSM to IDLE.
REQ-023 No request SHALL be accepted on the edge that leaves RESP; the next acceptance occurs no earlier than the following edge (one idle cycle minimum).
REQ-024 A load to the same word after a completed store SHALL return the stored value.
REQ-025 Array contents SHALL be uninitialized (x) except where written.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-027 A reset asserted in WAIT SHALL discard the pending request; an uncommitted store SHALL NOT modify the array.
REQ-028 Reset SHALL NOT clear array contents.

Configuration
REQ-029 The macro DMEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-030 When DMEM_ALIGN_CHECK_EN is defined, a request with req_addr[1:0]!=0 SHALL follow normal timing, SHALL NOT write the array, and SHALL respond with rsp_err=1 and rsp_data=0.
REQ-031 When DMEM_ALIGN_CHECK_EN is not defined, req_addr[1:0] SHALL be ignored and rsp_err SHALL be tied to 0.

Verification
REQ-032 LATENCY=2: store 0x5 to addr 0, then load addr 0 -> each rsp_valid appears exactly 2 falling edges after acceptance; load rsp_data=0x00000005.
REQ-033 Load addr 4 holding 0x7 with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_data=0x00000007 stable throughout; req_ready=0 until the edge after rsp_ready=1.
REQ-034 Store 0x7 to addr 4 (old value 0x5), reset_n pulsed low in WAIT, then load addr 4 -> returns 0x00000005; outputs were reset values during reset.
REQ-035 DEPTH=1024: store 0xA to addr 4096, then load addr 0 -> returns 0x0000000A (wrap).
REQ-036 With DMEM_ALIGN_CHECK_EN: store 0x9 to addr 2 -> rsp_err=1, rsp_data=0, and a load of addr 0 returns the prior value. Without the macro: the same store writes word 0, and the load returns 0x00000009.
REQ-037 LATENCY=1: back-to-back requests with rsp_ready held at 1 -> acceptances are 2 edges apart, and each response follows 1 edge after its acceptance.

Source files
------------

// File: rtl/dmem_responder.sv
// Falling-edge data memory responder: IDLE/WAIT/RESP handshake with a programmable access latency.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            write_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            mis_q;
  logic [31:0]     rsp_data_q;
  logic            from_mem_q;
  logic            err_q;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     mem_rdata_q;

  logic            req_mis;
  logic            accept;
  logic            enter_resp;
  logic            cur_write;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic            cur_mis;
  logic            mem_we;
  logic            mem_re;
  logic            unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = |req_addr[1:0];
`else
  assign req_mis = 1'b0;
`endif

  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  assign accept = (state_q == IDLE) && req_valid;

  // With LATENCY=1 the access happens on the acceptance edge, so it must use the live inputs.
  always_comb begin
    cur_write = write_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_mis   = mis_q;
    if (state_q == IDLE) begin
      cur_write = req_write;
      cur_idx   = req_addr[AW+1:2];
      cur_wdata = req_wdata;
      cur_mis   = req_mis;
    end
  end

  assign enter_resp = (LATENCY == 1) ? accept
                                     : ((state_q == WAIT) && (cnt_q == CW'(1)));

  assign mem_we = enter_resp && cur_write && !cur_mis && reset_n;
  assign mem_re = enter_resp && !cur_write && !cur_mis;

  always_ff @(negedge clock) begin
    if (mem_we) mem[cur_idx] <= cur_wdata;
    if (mem_re) mem_rdata_q <= mem[cur_idx];
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      rsp_data_q <= '0;
      from_mem_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            mis_q   <= req_mis;
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Response payload is frozen from the RESP entry edge until the handshake completes.
      if (enter_resp) begin
        rsp_data_q <= (cur_write && !cur_mis) ? cur_wdata : 32'h0;
        from_mem_q <= !cur_write && !cur_mis;
        err_q      <= cur_mis;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = from_mem_q ? mem_rdata_q : rsp_data_q;
  assign rsp_err   = err_q;

endmodule
